// File: rtl/window_3x3_stream_if.sv
// Stream bus for window_3x3_stream: raster pixel input with ready/valid,
// 3x3 window output with centre coordinates and frame markers.
interface window_3x3_stream_if #(
  parameter int DATA_W = 26
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   out_win;
  logic [15:0]           out_x;
  logic [15:0]           out_y;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_win, out_x, out_y, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_win, out_x, out_y, out_sof, out_eof
  );
endinterface

// File: rtl/window_3x3_stream.sv
// Streaming 3x3 neighbourhood generator.
// Two line buffers hold the two rows above the incoming pixel; every push
// shifts one new column into a 3x3 register window whose centre trails the
// push by IMG_W+1 pixels. After the last pixel of a frame, FLUSH makes
// IMG_W+1 internal pushes so the final row of windows drains out.
// Border handling: BORDER_REPLICATE_EN defined -> edge replicate,
// undefined -> out-of-image neighbours read as 0.
module window_3x3_stream #(
  parameter int IMG_W  = 636,
  parameter int IMG_H  = 508,
  parameter int DATA_W = 26
) (
  input logic                clk,
  input logic                rst_n,
  window_3x3_stream_if.slave s
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                         state;
  logic [XW-1:0]                  px;      // column of the next push
  logic [15:0]                    py;      // row of the next push
  logic [15:0]                    cx, cy;  // centre of the next emitted window
  logic [DATA_W-1:0]              lb0 [IMG_W];  // row y-1
  logic [DATA_W-1:0]              lb1 [IMG_W];  // row y-2
  logic [2:0][2:0][DATA_W-1:0]    w, w_nxt, w_row, w_brd;  // [row][col]
  logic [9*DATA_W-1:0]            win_flat;
  logic                           accept, push, emit;
  logic [DATA_W-1:0]              push_data;
  logic                           top_ok, bot_ok, lft_ok, rgt_ok;
  logic                           px_last, cx_last, cy_last;

  assign accept    = s.in_valid & s.in_ready;
  assign push      = accept | (state == FLUSH);
  assign emit      = push & (state != FILL);
  assign push_data = accept ? s.in_data : '0;

  assign px_last = (px == XW'(IMG_W-1));
  assign cx_last = (cx == 16'(IMG_W-1));
  assign cy_last = (cy == 16'(IMG_H-1));

  assign top_ok = (cy != 16'd0);
  assign bot_ok = !cy_last;
  assign lft_ok = (cx != 16'd0);
  assign rgt_ok = !cx_last;

  // Window after this push: shift left, new column from line buffers + pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_nxt[r][0] = w[r][1];
      w_nxt[r][1] = w[r][2];
    end
    w_nxt[0][2] = lb1[px];
    w_nxt[1][2] = lb0[px];
    w_nxt[2][2] = push_data;
  end

  // Border substitution; rows first so corners pick up the row fix too.
  always_comb begin
    w_row = w_nxt;
`ifdef BORDER_REPLICATE_EN
    if (!top_ok) w_row[0] = w_nxt[1];
    if (!bot_ok) w_row[2] = w_nxt[1];
    w_brd = w_row;
    for (int r = 0; r < 3; r++) begin
      if (!lft_ok) w_brd[r][0] = w_row[r][1];
      if (!rgt_ok) w_brd[r][2] = w_row[r][1];
    end
`else
    if (!top_ok) w_row[0] = '0;
    if (!bot_ok) w_row[2] = '0;
    w_brd = w_row;
    for (int r = 0; r < 3; r++) begin
      if (!lft_ok) w_brd[r][0] = '0;
      if (!rgt_ok) w_brd[r][2] = '0;
    end
`endif
  end

  // Flatten so p11 (top-left) lands in the MSBs and p33 in the LSBs.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[(8-(r*3+c))*DATA_W +: DATA_W] = w_brd[r][c];
  end

  // Line buffers: not reset, stale contents never reach an unmasked tap.
  always_ff @(posedge clk) begin
    if (push) begin
      lb1[px] <= lb0[px];
      lb0[px] <= push_data;
    end
  end

  // Control FSM, window registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      px          <= '0;
      py          <= '0;
      cx          <= '0;
      cy          <= '0;
      w           <= '0;
      s.in_ready  <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_win   <= '0;
      s.out_x     <= '0;
      s.out_y     <= '0;
      s.out_sof   <= 1'b0;
      s.out_eof   <= 1'b0;
    end else begin
      s.out_valid <= emit;
      s.in_ready  <= (state != FLUSH);
      if (push) begin
        w  <= w_nxt;
        px <= px_last ? '0 : px + 1'b1;
        if (px_last) py <= py + 16'd1;
      end
      if (emit) begin
        s.out_win <= win_flat;
        s.out_x   <= cx;
        s.out_y   <= cy;
        s.out_sof <= (cx == 16'd0) && (cy == 16'd0);
        s.out_eof <= cx_last && cy_last;
        cx        <= cx_last ? 16'd0 : cx + 16'd1;
        if (cx_last) cy <= cy_last ? 16'd0 : cy + 16'd1;
      end
      case (state)
        FILL: if (accept && px == '0 && py == 16'd1) state <= RUN;
        RUN: if (accept && px_last && py == 16'(IMG_H-1)) begin
          state      <= FLUSH;
          s.in_ready <= 1'b0;
        end
        FLUSH: if (cx_last && cy_last) begin
          state      <= FILL;
          px         <= '0;
          py         <= '0;
          s.in_ready <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/window_3x3_stream.md
WINDOW_3X3_STREAM -- requirements
Module: window_3x3_stream

Interface
REQ-001 Parameter IMG_W, default 636, pixels per line (min 3).
REQ-002 Parameter IMG_H, default 508, lines per frame (min 3).
REQ-003 Parameter DATA_W, default 26, bits per pixel.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  in_data carries a pixel.
REQ-007 in_data  input  DATA_W  raster-order pixel.
REQ-008 in_ready  output  1  block accepts a pixel this cycle.
REQ-009 out_valid  output  1  out_win is valid, 1-cycle pulse per window.
REQ-010 out_win  output  9*DATA_W  window, p11 in MSBs to p33 in LSBs, row-major, p22 = centre.
REQ-011 out_x  output  16  centre column.
REQ-012 out_y  output  16  centre row.
REQ-013 out_sof  output  1  asserted with the window at (0,0).
REQ-014 out_eof  output  1  asserted with the window at (IMG_W-1,IMG_H-1).

Function
REQ-015 Accept = in_valid & in_ready; non-accept cycles hold all state and deassert out_valid.
REQ-016 The block uses two internal line buffers of IMG_W x DATA_W and a 3x3 register window; no vendor IP.
REQ-017 State machine FILL -> RUN -> FLUSH -> FILL.
REQ-018 FILL: in_ready=1; the first IMG_W+1 accepts of a frame produce no output; the (IMG_W+1)th accept moves to RUN.
REQ-019 RUN: in_ready=1; each accept of stream index n (n = y*IMG_W+x) produces the window centred at index n-IMG_W-1 one cycle later.
REQ-020 After the accept of the last pixel (IMG_W*IMG_H-1), state goes to FLUSH.
REQ-021 FLUSH: in_ready=0; the block generates IMG_W+1 internal pushes at one per cycle, each producing one window; after the last push, state returns to FILL.
REQ-022 Exactly IMG_W*IMG_H windows per frame, in raster order, each centre exactly once.
REQ-023 Window neighbours outside the image (row -1, row IMG_H, col -1, col IMG_W) are replaced by the border value; no pixels wrap between lines.
REQ-024 in_valid during FLUSH is ignored; no data is lost or duplicated.
REQ-025 Back-to-back frames: the first accept after FLUSH is pixel (0,0) of the next frame.
REQ-026 out_x and out_y wrap at IMG_W-1 and IMG_H-1.
REQ-027 Line buffer contents are not reset; FILL masking and border substitution make stale data unobservable.

Reset
REQ-028 rst_n low on a clock edge: state=FILL, counters=0, out_valid=0, out_win=0, out_x=out_y=0, out_sof=out_eof=0, in_ready=0.
REQ-029 in_ready returns to 1 on the first cycle after rst_n is high.
REQ-030 Reset mid-frame or mid-FLUSH abandons the frame; the next accept is treated as pixel (0,0).

Configuration
REQ-031 Macro BORDER_REPLICATE_EN defined: the out-of-image neighbour takes the value of the nearest in-image pixel (edge replicate, corners included).
REQ-032 Macro BORDER_REPLICATE_EN undefined: the out-of-image neighbour is 0.

Verification
REQ-033 IMG_W=4, IMG_H=3, pixels 1..12 streamed continuously, macro off -> first out_valid 1 cycle after the 6th accept, window(0,0) = {0,0,0, 0,1,2, 0,5,6}, out_sof=1.
REQ-034 Same stimulus, macro on -> window(0,0) = {1,1,2, 1,1,2, 5,5,6}, window(3,2) = {7,8,8, 11,12,12, 11,12,12} with out_eof=1.
REQ-035 Same stimulus with in_valid held high through FLUSH -> in_ready=0 for exactly 5 cycles, 12 windows in total, and the next frame's first pixel is accepted as (0,0).
REQ-036 Random in_valid gaps (50%) -> window sequence identical to the gap-free run; out_valid never asserts on a non-accept, non-FLUSH cycle.
REQ-037 rst_n low for 1 cycle after the 7th accept, then a full new frame -> all outputs 0 during reset, and the new frame matches REQ-033 exactly.
REQ-038 Two back-to-back 4x3 frames -> 24 windows, out_sof and out_eof each asserted twice, and window (1,1) of frame 2 contains only frame-2 pixels.
